// File: rtl/elevator_scheduler.sv
// Single-car SCAN elevator scheduler: latches floor calls, times travel and door dwell.
// Optional feature macro: DOOR_REOPEN_EN (a same-floor call while the door is open restarts the dwell).
module elevator_scheduler #(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  callReq,
    output logic [9:0]  pending,
    output logic [3:0]  currentFloor,
    output logic [9:0]  floorOneHot,
    output logic        motorUp,
    output logic        motorDown,
    output logic        doorOpen,
    output logic        dirUp,
    output logic        busy
);

    localparam int unsigned N_FLOORS = 10;
    localparam int unsigned FW       = 4;
    localparam int unsigned TW       = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DW       = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    state_t                r_state;
    logic [FW-1:0]         r_floor;
    logic [N_FLOORS-1:0]   r_pending;
    logic                  r_dir_up;
    logic [TW-1:0]         r_travel_cnt;
    logic [DW-1:0]         r_door_cnt;

    logic [N_FLOORS-1:0]   w_req;
    logic [N_FLOORS-1:0]   w_cur_oh;
    logic [N_FLOORS-1:0]   w_next_oh;
    logic [N_FLOORS-1:0]   w_clr;
    logic [FW-1:0]         w_next_floor;
    logic                  w_travel_done;
    logic                  w_arrive_hit;
    logic                  w_ahead;
    logic                  w_above;
    logic                  w_below;
    logic                  w_cur_pending;
    logic                  w_reopen;
    logic [DW-1:0]         w_door_eff;
    logic                  w_door_done;

    function automatic logic calls_above(input logic [N_FLOORS-1:0] m, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FW'(i) > f && m[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic calls_below(input logic [N_FLOORS-1:0] m, input logic [FW-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (FW'(i) < f && m[i]) r = 1'b1;
        end
        return r;
    endfunction

    assign w_req         = r_pending | callReq;
    assign w_cur_oh      = N_FLOORS'(1) << r_floor;
    assign w_next_oh     = N_FLOORS'(1) << w_next_floor;
    assign w_travel_done = (r_travel_cnt == TW'(TRAVEL_CYCLES - 1));
    assign w_arrive_hit  = ((w_req & w_next_oh) != '0);
    assign w_cur_pending = ((r_pending & w_cur_oh) != '0);
    assign w_above       = calls_above(r_pending, r_floor);
    assign w_below       = calls_below(r_pending, r_floor);
    assign w_ahead       = (r_state == S_MOVE_UP) ? calls_above(w_req, w_next_floor)
                                                  : calls_below(w_req, w_next_floor);

`ifdef DOOR_REOPEN_EN
    assign w_reopen = ((callReq & w_cur_oh) != '0);
`else
    assign w_reopen = 1'b0;
`endif

    // A reopen call counts as the first cycle of a fresh dwell.
    assign w_door_eff  = w_reopen ? '0 : r_door_cnt;
    assign w_door_done = (w_door_eff == DW'(DOOR_CYCLES - 1));

    always_comb begin
        w_next_floor = r_floor;
        if (r_state == S_MOVE_UP)   w_next_floor = r_floor + FW'(1);
        if (r_state == S_MOVE_DOWN) w_next_floor = r_floor - FW'(1);
    end

    // Floor bit absorbed when its door is opening or already open.
    always_comb begin
        w_clr = '0;
        case (r_state)
            S_IDLE:      if (w_cur_pending) w_clr = w_cur_oh;
            S_MOVE_UP,
            S_MOVE_DOWN: if (w_travel_done && w_arrive_hit) w_clr = w_next_oh;
            S_DOOR_OPEN: w_clr = w_cur_oh;
            default:     w_clr = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_floor      <= '0;
            r_pending    <= '0;
            r_dir_up     <= 1'b1;
            r_travel_cnt <= '0;
            r_door_cnt   <= '0;
        end else begin
            r_pending <= w_req & ~w_clr;
            case (r_state)
                S_IDLE: begin
                    if (w_cur_pending) begin
                        r_state    <= S_DOOR_OPEN;
                        r_door_cnt <= '0;
                    end else if (w_above && (r_dir_up || !w_below)) begin
                        r_state      <= S_MOVE_UP;
                        r_dir_up     <= 1'b1;
                        r_travel_cnt <= '0;
                    end else if (w_below) begin
                        r_state      <= S_MOVE_DOWN;
                        r_dir_up     <= 1'b0;
                        r_travel_cnt <= '0;
                    end
                end
                S_MOVE_UP,
                S_MOVE_DOWN: begin
                    if (w_travel_done) begin
                        r_floor      <= w_next_floor;
                        r_travel_cnt <= '0;
                        if (w_arrive_hit) begin
                            r_state    <= S_DOOR_OPEN;
                            r_door_cnt <= '0;
                        end else if (!w_ahead) begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_travel_cnt <= r_travel_cnt + TW'(1);
                    end
                end
                S_DOOR_OPEN: begin
                    if (w_door_done) begin
                        r_state    <= S_IDLE;
                        r_door_cnt <= '0;
                    end else begin
                        r_door_cnt <= w_door_eff + DW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pending      = r_pending;
    assign currentFloor = r_floor;
    assign floorOneHot  = w_cur_oh;
    assign motorUp      = (r_state == S_MOVE_UP);
    assign motorDown    = (r_state == S_MOVE_DOWN);
    assign doorOpen     = (r_state == S_DOOR_OPEN);
    assign dirUp        = r_dir_up;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler: table of single-call trips plus hand-written corner sequences.
module tb_elevator_scheduler;

    localparam int unsigned TC = 4;
    localparam int unsigned DC = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] callReq = '0;
    logic [9:0] pending;
    logic [3:0] currentFloor;
    logic [9:0] floorOneHot;
    logic       motorUp, motorDown, doorOpen, dirUp, busy;

    elevator_scheduler #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
        .clock        (clock),
        .reset        (reset),
        .callReq      (callReq),
        .pending      (pending),
        .currentFloor (currentFloor),
        .floorOneHot  (floorOneHot),
        .motorUp      (motorUp),
        .motorDown    (motorDown),
        .doorOpen     (doorOpen),
        .dirUp        (dirUp),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned target;
        int unsigned lat;
        int unsigned motor;
        logic        dir;
    } trip_t;

    trip_t       trips[7];
    trip_t       sb[$];
    int unsigned floor_q[$];
    int unsigned door_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count edges (and motor-on cycles) until the door opens, bounded.
    task automatic wait_door(input logic up, output int k, output int m);
        k = 0;
        m = 0;
        while (!doorOpen && k < 200) begin
            if (up ? motorUp : motorDown) m++;
            @(negedge clock);
            k++;
        end
    endtask

    task automatic door_len(output int n);
        n = 0;
        while (doorOpen && n < 50) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run_trip(input trip_t t);
        int    k, m, n;
        trip_t e;
        @(negedge clock);
        callReq = 10'(1) << t.target;
        sb.push_back(t);
        @(negedge clock);
        callReq = '0;
        wait_door(t.dir, k, m);
        e = sb.pop_front();
        check("trip_latency",  32'(k), 32'(e.lat));
        check("trip_motor",    32'(m), 32'(e.motor));
        check("trip_floor",    32'(currentFloor), 32'(e.target));
        check("trip_onehot",   32'(floorOneHot), 32'(10'(1) << e.target));
        check("trip_dir",      32'(dirUp), 32'(e.dir));
        check("trip_pending",  32'(pending), 32'(0));
        check("trip_motoroff", 32'(motorUp | motorDown), 32'(0));
        door_len(n);
        check("trip_door_len", 32'(n), 32'(DC));
        check("trip_idle",     32'(busy), 32'(0));
    endtask

    initial begin
        int    k, m, n, cyc, doors;
        logic  injected, prev_door;
        logic [3:0] prev_floor;
        int unsigned exp_total;

        trips[0] = '{target: 0, lat: 1,  motor: 0,  dir: 1'b1};
        trips[1] = '{target: 3, lat: 13, motor: 12, dir: 1'b1};
        trips[2] = '{target: 7, lat: 17, motor: 16, dir: 1'b1};
        trips[3] = '{target: 2, lat: 21, motor: 20, dir: 1'b0};
        trips[4] = '{target: 9, lat: 29, motor: 28, dir: 1'b1};
        trips[5] = '{target: 0, lat: 37, motor: 36, dir: 1'b0};
        trips[6] = '{target: 1, lat: 5,  motor: 4,  dir: 1'b1};

        repeat (2) @(negedge clock);
        check("rst_floor",   32'(currentFloor), 32'(0));
        check("rst_onehot",  32'(floorOneHot), 32'(1));
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_dir",     32'(dirUp), 32'(1));
        check("rst_outs",    32'({motorUp, motorDown, doorOpen, busy}), 32'(0));
        reset = 1'b1;

        for (int i = 0; i < 7; i++) run_trip(trips[i]);

        // Up to 7 with a floor-2 call injected at 5, then reverse down to 2.
        @(negedge clock);
        callReq = 10'(1) << 7;
        floor_q = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2};
        door_q  = '{7, 2};
        @(negedge clock);
        callReq    = '0;
        prev_floor = currentFloor;
        prev_door  = doorOpen;
        injected   = 1'b0;
        doors      = 0;
        cyc        = 0;
        while (cyc < 400 && !(doors == 2 && !busy)) begin
            if (currentFloor != prev_floor) begin
                if (floor_q.size() > 0) check("scan_floor_seq", 32'(currentFloor), 32'(floor_q.pop_front()));
                else check("scan_extra_floor", 32'(currentFloor), 32'(99));
                prev_floor = currentFloor;
            end
            if (doorOpen && !prev_door) begin
                if (door_q.size() > 0) check("scan_door_floor", 32'(currentFloor), 32'(door_q.pop_front()));
                if (doors == 0) check("scan_pending_at7", 32'(pending), 32'(10'b0000000100));
                else check("scan_dir_down", 32'(dirUp), 32'(0));
                doors++;
            end
            prev_door = doorOpen;
            callReq   = '0;
            if (!injected && currentFloor == 4'd5) begin
                callReq  = 10'(1) << 2;
                injected = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        callReq = '0;
        check("scan_done_in_time", 32'(cyc < 400), 32'(1));
        check("scan_floor_left",   32'(floor_q.size()), 32'(0));

        // Same-edge arrival call at 6 while travelling 4 -> 8.
        run_trip('{target: 4, lat: 9, motor: 8, dir: 1'b1});
        @(negedge clock);
        callReq = 10'(1) << 8;
        @(posedge clock);
        @(negedge clock);
        callReq = '0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        check("edge_floor_before", 32'(currentFloor), 32'(5));
        check("edge_pending_before", 32'(pending), 32'(10'b0100000000));
        callReq = 10'(1) << 6;
        @(negedge clock);
        callReq = '0;
        check("edge_floor_at6",   32'(currentFloor), 32'(6));
        check("edge_door_at6",    32'(doorOpen), 32'(1));
        check("edge_pending_at6", 32'(pending), 32'(10'b0100000000));
        door_len(n);
        check("edge_door_len", 32'(n), 32'(DC));
        wait_door(1'b1, k, m);
        check("edge_floor_at8",   32'(currentFloor), 32'(8));
        check("edge_pending_at8", 32'(pending), 32'(0));
        door_len(n);

        // Same-floor call on door cycle 2 at floor 4.
        @(negedge clock);
        callReq = 10'(1) << 4;
        @(negedge clock);
        callReq = '0;
        wait_door(1'b0, k, m);
        check("reopen_floor", 32'(currentFloor), 32'(4));
        @(negedge clock);
        check("reopen_cycle2_open", 32'(doorOpen), 32'(1));
        callReq = 10'(1) << 4;
        @(negedge clock);
        callReq = '0;
        check("reopen_pending", 32'(pending), 32'(0));
        door_len(n);
`ifdef DOOR_REOPEN_EN
        exp_total = 4;
`else
        exp_total = 3;
`endif
        check("reopen_door_total", 32'(n + 2), 32'(exp_total));
        check("reopen_pending_end", 32'(pending), 32'(0));

        // Async reset while moving up from floor 2 toward 9.
        run_trip('{target: 2, lat: 9, motor: 8, dir: 1'b0});
        @(negedge clock);
        callReq = 10'(1) << 9;
        @(negedge clock);
        callReq = '0;
        @(negedge clock);
        check("rst_mid_motor_pre", 32'(motorUp), 32'(1));
        check("rst_mid_floor_pre", 32'(currentFloor), 32'(2));
        check("rst_mid_pend_pre",  32'(pending), 32'(10'b1000000000));
        #2 reset = 1'b0;
        #1;
        check("rst_mid_motor",   32'(motorUp), 32'(0));
        check("rst_mid_floor",   32'(currentFloor), 32'(0));
        check("rst_mid_pending", 32'(pending), 32'(0));
        check("rst_mid_busy",    32'(busy), 32'(0));
        check("rst_mid_onehot",  32'(floorOneHot), 32'(1));
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_rst_idle", 32'({busy, motorUp, doorOpen}), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
Single-car elevator scheduler for the 10-floor ride controller. It latches one-hot floor calls into a pending mask and tracks car position with an internal per-floor travel timer. Requests are served in SCAN order: keep moving in the current direction while calls remain ahead, otherwise reverse. It drives the motor and door outputs and reports the current floor both as a 4-bit index and as one-hot.

Parameters:
TRAVEL_CYCLES, 8, clock cycles to move one floor (must be >= 1)
DOOR_CYCLES, 4, clock cycles the door stays open per stop (must be >= 1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
callReq  input  10  one-hot or multi-hot floor call; bit i = floor i; sampled every cycle, may be a level or a pulse
pending  output  10  latched unserved calls
currentFloor  output  4  car floor index, 0..9
floorOneHot  output  10  one-hot of currentFloor
motorUp  output  1  car travelling up
motorDown  output  1  car travelling down
doorOpen  output  1  door open
dirUp  output  1  SCAN direction; 1 = up
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, currentFloor=0, floorOneHot=10'b1, pending=0, dirUp=1, travel/door counters=0, motorUp=motorDown=doorOpen=busy=0. All outputs are registered or decoded from registered state; no combinational path from callReq to outputs.
- Pending update each edge: pending <= (pending | callReq) & ~clr. clr is the current-floor bit when the door is opening or is already open.
- A call appears in pending one cycle after it is sampled.
- IDLE:
  - pending[cur] set -> DOOR_OPEN; clear that bit; load door counter.
  - Else, if any call above and (dirUp or no call below) -> MOVE_UP, dirUp=1.
  - Else, if any call below -> MOVE_DOWN, dirUp=0.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN:
  - motorUp (or motorDown) is high for the whole state.
  - The travel counter counts 0..TRAVEL_CYCLES-1. On the terminal count, currentFloor is incremented (or decremented) and the counter reloads.
  - Arrival decision uses the new floor and (pending | callReq) on the same edge. A call arriving on that edge stops the car and is absorbed, not left pending.
  - If the new floor is called -> DOOR_OPEN.
  - Else continue moving; a call is guaranteed ahead because the car only moves toward a call.
  - The car never moves below 0 or above 9. At floor 9, MOVE_UP is impossible; at floor 0, MOVE_DOWN is impossible.
- DOOR_OPEN:
  - doorOpen is high and both motors are low.
  - The door counter counts DOOR_CYCLES cycles, then the state returns to IDLE. IDLE re-evaluates on the next edge, so the dwell is exactly DOOR_CYCLES cycles of doorOpen.
  - A call for the current floor during DOOR_OPEN is cleared and never enters pending. Timer handling is set by the optional feature.
- Direction retention: dirUp persists through DOOR_OPEN and IDLE. It flips only when IDLE finds calls solely on the opposite side.
- Simultaneous calls above and below in IDLE: follow dirUp.
- Reset asserted mid-move or mid-door: immediate return to reset values. Pending calls are lost.

Optional Feature:
DOOR_REOPEN_EN
- Defined: a call for the current floor during DOOR_OPEN reloads the door counter, extending the dwell to a full DOOR_CYCLES from that cycle.
- Undefined: the call is absorbed without changing the timer, and the door closes on the original schedule.

Test Plan:
1. Reset, TRAVEL_CYCLES=4, DOOR_CYCLES=3; pulse callReq=10'b0000000001 for 1 cycle -> pending[0] never sticks; doorOpen high exactly 3 cycles starting 2 edges after the pulse; currentFloor stays 0; busy returns to 0.
2. From floor 0, pulse call floor 3 -> motorUp high 12 cycles; currentFloor steps 1, 2, 3 every 4 cycles; doorOpen for 3 cycles at floor 3; pending=0; dirUp=1.
3. Car at 5 moving up with pending floors 7 and 2 -> stops at 7 first, then dirUp=0 and MOVE_DOWN to 2; currentFloor sequence 5, 6, 7, 6, 5, 4, 3, 2.
4. Car travelling 4->8; call floor 6 asserted on the same edge the car reaches 6 -> stops at 6, pending[6]=0, then continues to 8.
5. reset low mid-MOVE_UP at floor 2 with pending=10'b1000000000 -> motorUp=0, currentFloor=0, pending=0, state IDLE, asynchronously before the next clock.
6. Door open at floor 4 with DOOR_CYCLES=3; call floor 4 on door cycle 2 -> with DOOR_REOPEN_EN, doorOpen lasts 4 cycles total; without it, 3 cycles; pending[4] stays 0 in both builds.
